// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. It accepts one
// M-extension op, requests a pipeline stall while it computes, then presents
// the result and its destination register for one cycle (done).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] dvs_q, quot_q, rem_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_quot_q, neg_rem_q;
  logic [4:0]      rd_q;

  // Accept-time decode of the incoming op.
  logic            accept;
  logic            div_signed_in, a_neg_in, b_neg_in;
  logic            div_zero_in, div_ovf_in, div_special_in;
  logic [XLEN-1:0] special_res;

  assign accept         = (state == S_IDLE) && start && !flush;
  assign div_signed_in  = !funct3[0];
  assign a_neg_in       = div_signed_in && op_a[XLEN-1];
  assign b_neg_in       = div_signed_in && op_b[XLEN-1];
  assign div_zero_in    = (op_b == '0);
  assign div_ovf_in     = div_signed_in && (op_a == MIN_NEG) && (op_b == '1);
  assign div_special_in = funct3[2] && (div_zero_in || div_ovf_in);

  // Divide-by-zero and signed overflow resolve without iterating.
  always_comb begin
    if (div_zero_in) special_res = funct3[1] ? op_a : '1;
    else             special_res = funct3[1] ? '0 : MIN_NEG;
  end

  // Multiply: extend each operand by one bit so MULHSU can mix signedness.
  logic                   mul_a_sgn, mul_b_sgn;
  logic signed [XLEN:0]   mul_a, mul_b;
  logic signed [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]        mul_res;

  always_comb begin
    mul_a_sgn = (f3_q[1:0] != 2'b11) && a_q[XLEN-1];
    mul_b_sgn = !f3_q[1] && b_q[XLEN-1];
    mul_a     = {mul_a_sgn, a_q};
    mul_b     = {mul_b_sgn, b_q};
    mul_full  = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);
    mul_res   = (f3_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
  end

  // Restoring divide step on magnitudes, plus sign correction of the final step.
  logic [XLEN:0]   rem_sh, diff;
  logic            q_bit, div_last;
  logic [XLEN-1:0] rem_nxt, quot_nxt, div_res;

  always_comb begin
    rem_sh   = {rem_q, quot_q[XLEN-1]};
    diff     = rem_sh - {1'b0, dvs_q};
    q_bit    = !diff[XLEN];
    rem_nxt  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quot_nxt = {quot_q[XLEN-2:0], q_bit};
    div_last = (cnt_q == CW'(XLEN-1));
    if (f3_q[1]) div_res = neg_rem_q  ? -rem_nxt  : rem_nxt;
    else         div_res = neg_quot_q ? -quot_nxt : quot_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush kills whatever is in flight.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if (!funct3[2])          state_nxt = S_MUL;
          else if (div_special_in) state_nxt = S_DONE;
          else                     state_nxt = S_DIV;
        end
        S_MUL:  state_nxt = S_DONE;
        S_DIV:  if (div_last) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand capture, divide iteration and result/rd registers.
  always_ff @(posedge clk) begin
    // NOTE: every datapath register is cleared on reset, so nothing stale leaks out after rst.
    if (rst) begin
      f3_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      dvs_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rd_q       <= '0;
      result     <= '0;
      rd_out     <= '0;
    end else if (accept) begin
      // NOTE: non-blocking so all registers update from pre-edge values.
      f3_q       <= funct3;
      a_q        <= op_a;
      b_q        <= op_b;
      dvs_q      <= b_neg_in ? -op_b : op_b;
      quot_q     <= a_neg_in ? -op_a : op_a;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quot_q <= a_neg_in ^ b_neg_in;
      neg_rem_q  <= a_neg_in;
      rd_q       <= rd_in;
      if (div_special_in) begin
        result <= special_res;
        rd_out <= rd_in;
      end
    end else if (!flush) begin
      case (state)
        S_MUL: begin
          result <= mul_res;
          rd_out <= rd_q;
        end
        S_DIV: begin
          quot_q <= quot_nxt;
          rem_q  <= rem_nxt;
          cnt_q  <= cnt_q + 1'b1;
          if (div_last) begin
            result <= div_res;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign stall_req = !rst && (accept || state == S_MUL || state == S_DIV);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized ops
// against an arithmetic reference model, flush, reset and back-to-back starts.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
    .busy(busy), .stall_req(stall_req), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: RISC-V M semantics in plain 64-bit arithmetic, plus latency.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    if (!f3[2]) begin
      lat = 2;
      case (f3[1:0])
        2'b00: begin sp = sa * sb;           r = sp[31:0];  end
        2'b01: begin sp = sa * sb;           r = sp[63:32]; end
        2'b10: begin sp = sa * longint'(ub); r = sp[63:32]; end
        default: begin up = ua * ub;         r = up[63:32]; end
      endcase
    end else if (b == 32'h0) begin
      lat = 1;
      r = f3[1] ? a : 32'hFFFF_FFFF;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 1;
      r = f3[1] ? 32'h0 : 32'h8000_0000;
    end else begin
      lat = 33;
      case (f3[1:0])
        2'b00: begin sp = sa / sb; r = sp[31:0]; end
        2'b01: begin up = ua / ub; r = up[31:0]; end
        2'b10: begin sp = sa % sb; r = sp[31:0]; end
        default: begin up = ua % ub; r = up[31:0]; end
      endcase
    end
  endfunction

  // Called just after the accept edge; scrambles operands while computing.
  task automatic wait_done(input int lat, input logic [31:0] exp, input logic [4:0] rd);
    int cyc;
    cyc = 0;
    #1 start = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (!done) begin
        if (cyc == 1) check("stall_busy", stall_req, 1'b1);
        op_a = $urandom;
        op_b = $urandom;
      end
    end while (!done && cyc < 60);
    check("latency", cyc, lat);
    check("result", result, exp);
    check("rd_out", rd_out, rd);
    check("stall_done", stall_req, 1'b0);
    @(negedge clk);
    check("done_once", done, 1'b0);
    check("idle_after", busy, 1'b0);
    last_res = exp;
    last_rd  = rd;
  endtask

  // Starts an op at a negedge while idle and follows it to completion.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    logic [31:0] exp;
    int lat;
    model(f3, a, b, exp, lat);
    funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    #1 check("stall_accept", stall_req, 1'b1);
    @(posedge clk);
    wait_done(lat, exp, rd);
  endtask

  initial begin
    logic [31:0] e1, e2, ra, rb;
    logic [2:0]  rf;
    int l1, l2;

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_rd", rd_out, 5'd0);
    check("rst_stall", stall_req, 1'b0);
    rst = 1'b0;
    last_res = '0; last_rd = '0;

    // Directed cases.
    run_op(3'b000, 32'd7, 32'd6, 5'd5);
    check("mul_7x6", result, 32'h2A);
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 5'd1);
    run_op(3'b011, 32'hFFFF_FFFE, 32'd3, 5'd2);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'b101, 32'd100, 32'd7, 5'd7);
    run_op(3'b111, 32'd100, 32'd7, 5'd8);
    run_op(3'b101, 32'h1234, 32'h0, 5'd9);
    run_op(3'b110, 32'h1234, 32'h0, 5'd10);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);

    // flush together with start in IDLE: start ignored.
    funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd12; start = 1'b1; flush = 1'b1;
    #1 check("flush_start_stall", stall_req, 1'b0);
    @(negedge clk);
    check("flush_start_busy", busy, 1'b0);
    start = 1'b0; flush = 1'b0;

    // Flush at cycle 10 of a divide.
    funct3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2; rd_in = 5'd13; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) check("flush_early_done", done, 1'b0);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", busy, 1'b0);
    check("flush_no_done", done, 1'b0);
    check("flush_result", result, last_res);
    check("flush_rd", rd_out, last_rd);
    run_op(3'b000, 32'd12, 32'd12, 5'd14);

    // Back-to-back: start held through the DONE cycle with a second op.
    model(3'b000, 32'd9, 32'd11, e1, l1);
    model(3'b101, 32'd1000, 32'd33, e2, l2);
    funct3 = 3'b000; op_a = 32'd9; op_b = 32'd11; rd_in = 5'd15; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_c1_done", done, 1'b0);
    @(negedge clk);
    check("b2b_done1", done, 1'b1);
    check("b2b_res1", result, e1);
    check("b2b_rd1", rd_out, 5'd15);
    funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd33; rd_in = 5'd16;
    @(negedge clk);
    check("b2b_c3_done", done, 1'b0);
    check("b2b_c3_busy", busy, 1'b0);
    check("b2b_c3_stall", stall_req, 1'b1);
    @(posedge clk);
    wait_done(l2, e2, 5'd16);

    // Randomized ops against the model, with boundary operands mixed in.
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op(rf, ra, rb, 5'($urandom_range(0, 31)));
    end

    // Reset asserted mid-divide.
    funct3 = 3'b101; op_a = 32'hDEAD_BEEF; op_b = 32'd3; rd_in = 5'd17; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_rd", rd_out, 5'd0);
    check("mid_rst_stall", stall_req, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- It is the producer side of the EX-stage hazard path: it accepts an M-extension op, raises a stall request while computing, then presents a one-cycle result with its destination register for writeback and forwarding.
- Multiply takes a fixed 2 cycles; divide/remainder uses a radix-2 restoring algorithm (one quotient bit per cycle).

Parameters:
XLEN, 32, operand/result width; the divide iteration count equals XLEN.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request new op; sampled only in IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 value (forwarded operand)
op_b  input  XLEN  rs2 value (forwarded operand)
rd_in  input  5  destination register of the op
flush  input  1  kill in-flight op (branch mispredict/redirect)
busy  output  1  state != IDLE
stall_req  output  1  freeze IF/ID/EX: (IDLE & start & ~flush) | MUL | DIV
done  output  1  one-cycle pulse; result/rd_out valid
result  output  XLEN  selected result, held until next done
rd_out  output  5  destination of the completed op, held with result

Behaviour:
- Reset (rst high at edge): state=IDLE, busy=0, done=0, result=0, rd_out=0, all internal registers cleared. stall_req=0 while rst is high. Reset overrides start and flush in any state, including mid-divide.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0: latch funct3, op_a, op_b, rd_in.
  - funct3[2]=0 -> MUL.
  - Divide with op_b==0 or signed overflow -> DONE directly.
  - Other divides -> DIV.
  - start while not IDLE is ignored.
- MUL (1 cycle): register the 64-bit product with signedness per funct3.
  - MULHSU: op_a signed, op_b unsigned.
  - Result = low word for MUL, high word otherwise.
  - Then -> DONE.
- DIV: operate on absolute values for signed ops.
  - Each cycle: shift partial remainder, conditional subtract, shift in one quotient bit; 5-bit iteration counter runs 0..XLEN-1.
  - On the last iteration, apply sign correction: quotient negated if operand signs differ; remainder takes dividend sign. Register the selected result, then -> DONE.
- Special cases (RISC-V spec, no trap):
  - divide by zero: DIV/DIVU = 0xFFFFFFFF, REM/REMU = op_a.
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, REM 0.
- DONE: done=1 and stall_req=0 for exactly one cycle, with result/rd_out valid. Then -> IDLE unconditionally.
- Latency from start-accept edge (cycle 0):
  - MUL family: done at cycle 2.
  - Special-case divide: done at cycle 1.
  - Normal divide: done at cycle XLEN+1 (33).
- Back-to-back: the pipeline advances in the DONE cycle, so the next start arrives while the unit is IDLE and is accepted. Maximum throughput is one op per latency+1 cycles.
- flush: from any state, go to IDLE at the next edge. No done pulse for the killed op. result/rd_out keep their previous values. flush together with start in IDLE: start is ignored.
- rd_in=0 is processed normally. rd_out=0; suppressing the write is the consumer's responsibility.
- Operands are latched at accept; changes on op_a/op_b during MUL/DIV have no effect.

Test Plan:
- MUL 7 x 6, rd=5 -> stall_req high cycles 0-1, done at cycle 2, result=0x0000002A, rd_out=5, busy low at cycle 3.
- MULH 0xFFFFFFFE x 3 -> 0xFFFFFFFF; MULHU same operands -> 0x00000002; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> done at cycle 33, result 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- DIVU 0x1234 / 0 -> done at cycle 1, 0xFFFFFFFF. REM 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush at cycle 10 of a DIV -> IDLE at cycle 11, no done, result unchanged. A new MUL start at cycle 11 completes normally. Separately, rst asserted mid-divide -> all outputs 0 next cycle.
- start held high through the DONE cycle with a second op -> first op done pulses once; second op accepted in IDLE the following cycle and completes with its own rd_out.
